fprn_cfg_loader: RTL and testbench

FPRN_CFG_LOADER -- requirements
Module: fprn_cfg_loader

---
 rtl/fprn_pkg.sv | 24 ++
 rtl/fprn_shadow_bank.sv | 46 ++++
 rtl/fprn_cfg_loader.sv | 138 +++++++++++++
 tb/tb_fprn_cfg_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fprn_pkg.sv
// Shared definitions for the FPRN configuration loader: command encodings,
// FSM state type, parameter defaults and a pointer-width helper.
package fprn_pkg;

    localparam int NBYTES_DEF     = 16;
    localparam int BBM_CYCLES_DEF = 4;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_BBM  = 2'd2
    } fprn_state_e;

    // A single-byte bank still needs a one-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fprn_shadow_bank.sv
// NBYTES x 8 shadow storage: one synchronous write port, synchronous clear,
// a combinational read port and the full vector presented in parallel.
module fprn_shadow_bank
    import fprn_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF,
    parameter int PW     = ptr_width(NBYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [PW-1:0]         wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  clr,
    input  logic [PW-1:0]         rd_addr,
    output logic [7:0]            rd_data,
    output logic [NBYTES*8-1:0]   vec
);

    logic [7:0] mem [NBYTES];

    // Clear wins over write; the FSM never asserts both in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (clr) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

    always_comb begin
        vec = '0;
        for (int i = 0; i < NBYTES; i++) begin
            vec[8*i +: 8] = mem[i];
        end
    end

endmodule

// File: rtl/fprn_cfg_loader.sv
// Configuration loader for a programmable resistor network: byte-wise shadow
// writes, readback, and break-before-make commit of the shadow to sw_en.
module fprn_cfg_loader
    import fprn_pkg::*;
#(
    parameter int NBYTES     = NBYTES_DEF,
    parameter int BBM_CYCLES = BBM_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [7:0]            cmd_data,
    output logic                  rd_valid,
    output logic [7:0]            rd_data,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic [NBYTES*8-1:0]   sw_en,
    output fprn_state_e           state_dbg
);

    localparam int            PW       = ptr_width(NBYTES);
    localparam logic [PW-1:0] LAST_IDX = PW'(NBYTES - 1);
    localparam logic [7:0]    CNT_INIT = 8'(BBM_CYCLES - 1);

    fprn_state_e          state, state_nx;
    logic [PW-1:0]        wptr, wptr_nx;
    logic [PW-1:0]        rptr, rptr_nx;
    logic [7:0]           cnt, cnt_nx;
    logic [NBYTES*8-1:0]  active;
    logic [NBYTES*8-1:0]  shadow_vec;
    logic                 bank_wr, bank_clr, load_active;
    logic                 cmd_acc, rd_hs;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and the offered data/op
    // must stay stable until that edge.
    assign cmd_ready = ena && (state == ST_IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign rd_valid  = (state == ST_READ);
    assign rd_hs     = rd_valid && rd_ready;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Blanking during BBM guarantees no cycle mixes old and new switch bits.
    assign sw_en = (state == ST_BBM) ? '0 : active;

    always_comb begin
        state_nx    = state;
        wptr_nx     = wptr;
        rptr_nx     = rptr;
        cnt_nx      = cnt;
        bank_wr     = 1'b0;
        bank_clr    = 1'b0;
        load_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            bank_wr = 1'b1;
                            wptr_nx = (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
                        end
                        OP_READ: begin
                            rptr_nx  = '0;
                            state_nx = ST_READ;
                        end
                        OP_COMMIT: begin
                            cnt_nx   = CNT_INIT;
                            state_nx = ST_BBM;
                        end
                        OP_CLEAR: begin
                            bank_clr = 1'b1;
                            wptr_nx  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_READ: begin
                if (rd_hs) begin
                    if (rptr == LAST_IDX) begin
                        rptr_nx  = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        rptr_nx = rptr + 1'b1;
                    end
                end
            end
            ST_BBM: begin
                if (cnt == 8'd0) begin
                    load_active = 1'b1;
                    wptr_nx     = '0;
                    state_nx    = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= 8'd0;
            active <= '0;
        end else begin
            state <= state_nx;
            wptr  <= wptr_nx;
            rptr  <= rptr_nx;
            cnt   <= cnt_nx;
            if (load_active) begin
                active <= shadow_vec;
            end
        end
    end

    fprn_shadow_bank #(
        .NBYTES (NBYTES),
        .PW     (PW)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bank_wr),
        .wr_addr (wptr),
        .wr_data (cmd_data),
        .clr     (bank_clr),
        .rd_addr (rptr),
        .rd_data (rd_data),
        .vec     (shadow_vec)
    );

endmodule

// File: tb/tb_fprn_cfg_loader.sv
// Self-checking bench for fprn_cfg_loader: byte model, readback scoreboard
// queue and timed break-before-make checks on sw_en.
module tb_fprn_cfg_loader;
    import fprn_pkg::*;

    localparam int NB  = 16;
    localparam int SW  = NB * 8;
    localparam int BBM = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [7:0]     cmd_data;
    logic           rd_valid;
    logic [7:0]     rd_data;
    logic           rd_ready;
    logic           busy;
    logic [SW-1:0]  sw_en;
    fprn_state_e    state_dbg;

    fprn_cfg_loader #(.NBYTES(NB), .BBM_CYCLES(BBM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .sw_en     (sw_en),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model and scoreboard
    logic [7:0]    sh_m [NB];
    int            wptr_m;
    logic [SW-1:0] act_m;
    logic [SW-1:0] pend_m;
    logic [7:0]    exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            dummy;
    int            last_hs_cyc;
    int            wr_acc_cyc;

    task automatic check(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] vec_m();
        logic [SW-1:0] v;
        for (int i = 0; i < NB; i++) v[8*i +: 8] = sh_m[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) sh_m[i] = 8'h00;
        wptr_m = 0;
        act_m  = '0;
        exp_q.delete();
    endtask

    // driver: offer a command, wait (bounded) for acceptance, update the model
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, output int acc_cyc);
        bit done = 0;
        acc_cyc = -1;
        @(negedge clk);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                done = 1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!done) begin
            check("cmd_accept_timeout", 0, 1);
        end else begin
            case (op)
                OP_WRITE: begin
                    sh_m[wptr_m] = data;
                    wptr_m = (wptr_m + 1) % NB;
                end
                OP_READ: for (int i = 0; i < NB; i++) exp_q.push_back(sh_m[i]);
                OP_COMMIT: begin
                    pend_m = vec_m();
                    wptr_m = 0;
                end
                default: begin
                    for (int i = 0; i < NB; i++) sh_m[i] = 8'h00;
                    wptr_m = 0;
                end
            endcase
        end
    endtask

    // called right after a COMMIT is accepted
    task automatic wait_bbm(input string tag);
        for (int i = 0; i < BBM; i++) begin
            @(negedge clk);
            check({tag, "_bbm_sw_zero"}, sw_en, '0);
            check({tag, "_bbm_busy"}, busy, 1);
        end
        @(negedge clk);
        act_m = pend_m;
        check({tag, "_sw_new"}, sw_en, act_m);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    // readback collector: mode 0 = rd_ready held high, mode 1 = toggling
    task automatic collect(input int mode, output int last_cyc);
        int         got = 0;
        logic [7:0] held = 8'h00;
        bit         have_held = 0;
        logic [7:0] e;
        last_cyc = -1;
        rd_ready = (mode == 0);
        for (int g = 0; g < 400 && got < NB; g++) begin
            @(negedge clk);
            if (have_held) check("rd_hold_stable", rd_data, held);
            have_held = 0;
            check("rd_valid_in_read", rd_valid, 1);
            check("cmd_ready_in_read", cmd_ready, 0);
            if (!rd_valid) continue;
            if (mode == 1) rd_ready = ~rd_ready;
            if (rd_ready) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected_byte", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end
                got++;
                @(posedge clk);
                #1;
                last_cyc = cyc;
            end else begin
                held = rd_data;
                have_held = 1;
            end
        end
        rd_ready = 1'b0;
        if (got < NB) check("rd_timeout", got, NB);
        @(negedge clk);
        check("rd_valid_after_last", rd_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        rd_ready  = 1'b0;
        pend_m    = '0;
        model_reset();

        // reset state
        #1;
        check("rst_sw_en", sw_en, '0);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state_idle", state_dbg, ST_IDLE);
        check("rst_cmd_ready", cmd_ready, 1);

        // two writes then commit
        do_cmd(OP_WRITE, 8'hA5, dummy);
        do_cmd(OP_WRITE, 8'h3C, dummy);
        do_cmd(OP_COMMIT, 8'h00, dummy);
        wait_bbm("commit1");
        check("commit1_const", sw_en, 128'h3CA5);

        // 17 writes wrap onto byte 0, full readback with rd_ready high
        for (int i = 1; i <= 17; i++) do_cmd(OP_WRITE, 8'(i), dummy);
        do_cmd(OP_READ, 8'h00, dummy);
        check("wrap_byte0_model", sh_m[0], 8'h11);
        collect(0, dummy);

        // stalled readback with a WRITE held pending
        do_cmd(OP_READ, 8'h00, dummy);
        fork
            do_cmd(OP_WRITE, 8'h77, wr_acc_cyc);
            collect(1, last_hs_cyc);
        join
        check("held_write_latency", wr_acc_cyc - last_hs_cyc, 1);

        // all-ones commit, CLEAR leaves sw_en, readback zeros, commit zeros
        for (int i = 0; i < NB; i++) do_cmd(OP_WRITE, 8'hFF, dummy);
        do_cmd(OP_COMMIT, 8'h00, dummy);
        wait_bbm("commit_ff");
        do_cmd(OP_CLEAR, 8'h00, dummy);
        @(negedge clk);
        check("clear_sw_unchanged", sw_en, {SW{1'b1}});
        do_cmd(OP_READ, 8'h00, dummy);
        collect(0, dummy);
        do_cmd(OP_COMMIT, 8'h00, dummy);
        wait_bbm("commit_zero");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sw_stays_zero", sw_en, '0);
        end

        // reset on the 2nd BBM cycle
        do_cmd(OP_WRITE, 8'h5A, dummy);
        do_cmd(OP_WRITE, 8'h5A, dummy);
        do_cmd(OP_COMMIT, 8'h00, dummy);
        wait_bbm("commit_5a");
        do_cmd(OP_WRITE, 8'hC3, dummy);
        do_cmd(OP_COMMIT, 8'h00, dummy);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("bbm_rst_sw_en", sw_en, '0);
        check("bbm_rst_busy", busy, 0);
        check("bbm_rst_rd_valid", rd_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_sw_zero", sw_en, act_m);
        end
        do_cmd(OP_READ, 8'h00, dummy);
        collect(0, dummy);

        // ena dropped mid-BBM, then ena low with a command offered
        do_cmd(OP_WRITE, 8'h11, dummy);
        do_cmd(OP_WRITE, 8'h22, dummy);
        do_cmd(OP_COMMIT, 8'h00, dummy);
        ena = 1'b0;
        wait_bbm("commit_ena_low");
        @(negedge clk);
        cmd_op    = OP_WRITE;
        cmd_data  = 8'h99;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ena_low_cmd_ready", cmd_ready, 0);
            check("ena_low_sw_en", sw_en, act_m);
        end
        cmd_valid = 1'b0;
        ena = 1'b1;
        do_cmd(OP_READ, 8'h00, dummy);
        collect(0, dummy);
        check("final_sw_en", sw_en, 128'h2211);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
